// File: rtl/div_unit_pkg.sv
// Shared definitions for the E-stage multi-cycle divider: state encoding,
// result-ready flags and the ALU control codes that launch a divide.
package div_unit_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_e;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;

  // ALU control codes that raise start (DIV -> signed, DIVU -> unsigned)
  localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

endpackage

// File: rtl/div_unit_if.sv
// Request/response bundle between the E-stage ALU and the divider.
interface div_unit_if
  import div_unit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
);
  logic                 start;
  logic                 is_signed;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 annul;
  logic                 busy;
  logic                 valid;
  logic [2*WIDTH-1:0]   result;

  modport master (
    output start, is_signed, a, b, annul,
    input  busy, valid, result
  );

  modport slave (
    input  start, is_signed, a, b, annul,
    output busy, valid, result
  );
endinterface

// File: rtl/div_unit.sv
// Restoring divider for DIV/DIVU: one quotient bit per cycle, signs fixed up
// on the last step so result = {remainder, quotient} is final when valid pulses.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input logic       clk,
  input logic       rst,
  div_unit_if.slave bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  div_state_e state, state_nx;

  logic [CW-1:0]    cnt;
  logic [2*WIDTH:0] acc;       // {partial remainder, dividend/quotient}
  logic [WIDTH-1:0] dvsr;
  logic             sign_q;
  logic             sign_r;

  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [2*WIDTH:0] acc_sh;
  logic [WIDTH:0]   trial;
  logic [2*WIDTH:0] acc_step;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic             cnt_last;

  // Operand magnitudes and one restoring step on the current accumulator.
  always_comb begin
    abs_a    = (bus.is_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    abs_b    = (bus.is_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;
    acc_sh   = acc << 1;
    trial    = acc_sh[2*WIDTH:WIDTH] - {1'b0, dvsr};
    acc_step = trial[WIDTH] ? acc_sh : {trial, acc_sh[WIDTH-1:1], 1'b1};
    quo      = sign_q ? -acc_step[WIDTH-1:0] : acc_step[WIDTH-1:0];
    rem      = sign_r ? -acc_step[2*WIDTH-1:WIDTH] : acc_step[2*WIDTH-1:WIDTH];
    cnt_last = (cnt == CNT_LAST);
  end

  always_ff @(posedge clk) begin
    // NOTE: state is updated with <= so every register samples pre-edge values.
    if (rst) state <= DIV_FREE;
    else     state <= state_nx;
  end

  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch behind.
    state_nx  = state;
    bus.busy  = 1'b0;
    bus.valid = DIV_RESULT_NOT_READY;
    unique case (state)
      DIV_FREE: begin
        if (bus.start) state_nx = (bus.b == '0) ? DIV_BY_ZERO : DIV_ON;
      end
      DIV_BY_ZERO: begin
        bus.busy = 1'b1;
        state_nx = DIV_END;
      end
      DIV_ON: begin
        bus.busy = 1'b1;
        if (cnt_last) state_nx = DIV_END;
      end
      DIV_END: begin
        bus.valid = DIV_RESULT_READY;
        state_nx  = DIV_FREE;
      end
      default: state_nx = DIV_FREE;
    endcase
    // An annulled op falls back to idle; a start seen in the same cycle is lost.
    if (bus.annul) state_nx = DIV_FREE;
  end

  always_ff @(posedge clk) begin
    // NOTE: the datapath is cleared too, so a reset leaves no stale operand or result.
    if (rst) begin
      cnt        <= '0;
      acc        <= '0;
      dvsr       <= '0;
      sign_q     <= 1'b0;
      sign_r     <= 1'b0;
      bus.result <= '0;
    end else if (!bus.annul) begin
      unique case (state)
        DIV_FREE: begin
          if (bus.start) begin
            acc    <= {{(WIDTH+1){1'b0}}, abs_a};
            dvsr   <= abs_b;
            sign_q <= bus.is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            sign_r <= bus.is_signed & bus.a[WIDTH-1];
            cnt    <= '0;
          end
        end
        DIV_BY_ZERO: bus.result <= '0;
        DIV_ON: begin
          acc <= acc_step;
          cnt <= cnt + 1'b1;
          if (cnt_last) bus.result <= {rem, quo};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Scenario bench for div_unit: expected results are queued at issue time and
// popped when valid pulses; timing of busy/valid is measured per operation.
module tb_div_unit;
  import div_unit_pkg::*;

  typedef struct {
    bit          sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  div_unit_if #(.WIDTH(32)) bus ();
  div_unit #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  int          errors = 0;
  int          checks = 0;
  logic [63:0] exp_q[$];
  logic [63:0] last_result;
  logic [63:0] exp_v;
  int          lat;
  int          nbusy;
  bit          got;
  logic        busy_at_valid;

  function automatic logic [63:0] model(bit sgn, logic [31:0] a, logic [31:0] b);
    logic signed [31:0] sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (!sgn) return {a % b, a / b};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
    sa = a;
    sb = b;
    q  = sa / sb;
    r  = sa % sb;
    return {r, q};
  endfunction

  // Drives start for one cycle; returns at the falling edge of cycle t+1.
  task automatic issue(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start     = 1'b1;
    bus.is_signed = sgn;
    bus.a         = a;
    bus.b         = b;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Counts busy cycles until valid; optionally pokes extra starts while busy.
  task automatic wait_done(input int limit, input bit poke);
    lat = 0; nbusy = 0; got = 0; busy_at_valid = 1'b0;
    for (int n = 1; n <= limit; n++) begin
      if (n > 1) @(negedge clk);
      if (poke) begin
        bus.start     = (n == 5 || n == 12);
        bus.is_signed = 1'b1;
        bus.a         = 32'd5555;
        bus.b         = 32'd3;
      end
      if (bus.valid) begin
        got = 1; lat = n; busy_at_valid = bus.busy;
        break;
      end
      if (bus.busy) nbusy++;
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", bus.valid); end
    checks++; if (bus.result !== 64'd0) begin errors++; $display("FAIL reset_result got=%h want=0", bus.result); end
    last_result = 64'd0;
  endtask

  task automatic test_divu_basic;
    exp_q.push_back({32'd2, 32'd14});
    issue(1'b0, 32'd100, 32'd7);
    wait_done(40, 1'b0);
    exp_v = exp_q.pop_front();
    checks++; if (!got || lat != 33) begin errors++; $display("FAIL divu_latency got=%0d want=33", lat); end
    checks++; if (nbusy != 32) begin errors++; $display("FAIL divu_busy_cycles got=%0d want=32", nbusy); end
    checks++; if (busy_at_valid !== 1'b0) begin errors++; $display("FAIL divu_busy_at_valid got=%b want=0", busy_at_valid); end
    checks++; if (bus.result !== exp_v) begin errors++; $display("FAIL divu_result got=%h want=%h", bus.result, exp_v); end
    last_result = exp_v;
  endtask

  task automatic test_vectors;
    vec_t vecs[$];
    vecs.push_back('{1'b1, 32'hFFFF_FFF9, 32'd2,         {32'hFFFF_FFFF, 32'hFFFF_FFFD}});
    vecs.push_back('{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0000_0000, 32'h8000_0000}});
    vecs.push_back('{1'b0, 32'hFFFF_FFFF, 32'd1,         {32'h0000_0000, 32'hFFFF_FFFF}});
    vecs.push_back('{1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, {32'hFFFF_FFFE, 32'h0000_000E}});
    vecs.push_back('{1'b0, 32'h8000_0000, 32'hFFFF_FFFF, {32'h8000_0000, 32'h0000_0000}});
    vecs.push_back('{1'b1, 32'd5,         32'd7,         {32'h0000_0005, 32'h0000_0000}});
    vecs.push_back('{1'b1, 32'd100,       32'hFFFF_FFF9, {32'h0000_0002, 32'hFFFF_FFF2}});
    foreach (vecs[i]) begin
      exp_q.push_back(vecs[i].exp);
      issue(vecs[i].sgn, vecs[i].a, vecs[i].b);
      wait_done(40, 1'b0);
      exp_v = exp_q.pop_front();
      checks++; if (!got || lat != 33) begin errors++; $display("FAIL vec%0d_latency got=%0d want=33", i, lat); end
      checks++; if (bus.result !== exp_v) begin errors++; $display("FAIL vec%0d_result got=%h want=%h", i, bus.result, exp_v); end
      last_result = exp_v;
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 6; i++) begin
      bit          sgn = 1'($urandom_range(0, 1));
      logic [31:0] a   = $urandom;
      logic [31:0] b   = $urandom >> $urandom_range(0, 31);
      if (b == 32'd0) b = 32'd1;
      exp_q.push_back(model(sgn, a, b));
      issue(sgn, a, b);
      wait_done(40, 1'b0);
      exp_v = exp_q.pop_front();
      checks++; if (!got || lat != 33) begin errors++; $display("FAIL rand%0d_latency got=%0d want=33", i, lat); end
      checks++; if (bus.result !== exp_v) begin errors++; $display("FAIL rand%0d_result a=%h b=%h s=%b got=%h want=%h", i, a, b, sgn, bus.result, exp_v); end
      last_result = exp_v;
    end
  endtask

  task automatic test_annul;
    bit seen = 0;
    issue(1'b0, 32'd100, 32'd7);
    for (int n = 2; n <= 9; n++) @(negedge clk);
    bus.annul = 1'b1;
    @(negedge clk);
    bus.annul = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL annul_busy got=%b want=0", bus.busy); end
    checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL annul_valid got=%b want=0", bus.valid); end
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (bus.valid) seen = 1;
    end
    checks++; if (seen) begin errors++; $display("FAIL annul_no_valid got=1 want=0"); end
    checks++; if (bus.result !== last_result) begin errors++; $display("FAIL annul_result_hold got=%h want=%h", bus.result, last_result); end
    exp_q.push_back({32'd1, 32'hFFFF_FFFC});
    issue(1'b1, 32'd9, 32'hFFFF_FFFE);
    wait_done(40, 1'b0);
    exp_v = exp_q.pop_front();
    checks++; if (!got || lat != 33) begin errors++; $display("FAIL post_annul_latency got=%0d want=33", lat); end
    checks++; if (bus.result !== exp_v) begin errors++; $display("FAIL post_annul_result got=%h want=%h", bus.result, exp_v); end
    last_result = exp_v;
  endtask

  task automatic test_annul_with_start;
    bit seen = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.annul = 1'b1; bus.is_signed = 1'b0;
    bus.a = 32'd50; bus.b = 32'd5;
    @(negedge clk);
    bus.start = 1'b0; bus.annul = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL annul_start_busy got=%b want=0", bus.busy); end
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (bus.valid || bus.busy) seen = 1;
    end
    checks++; if (seen) begin errors++; $display("FAIL annul_start_dropped got=active want=idle"); end
  endtask

  task automatic test_start_ignored;
    exp_q.push_back(model(1'b0, 32'd1000000, 32'd9));
    issue(1'b0, 32'd1000000, 32'd9);
    wait_done(40, 1'b1);
    exp_v = exp_q.pop_front();
    checks++; if (!got || lat != 33) begin errors++; $display("FAIL ignored_latency got=%0d want=33", lat); end
    checks++; if (nbusy != 32) begin errors++; $display("FAIL ignored_busy_cycles got=%0d want=32", nbusy); end
    checks++; if (bus.result !== exp_v) begin errors++; $display("FAIL ignored_result got=%h want=%h", bus.result, exp_v); end
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL ignored_no_restart got=%b want=0", bus.busy); end
    last_result = exp_v;
  endtask

  task automatic test_reset_mid;
    bit seen = 0;
    issue(1'b0, 32'd100, 32'd7);
    for (int n = 2; n <= 19; n++) begin
      @(negedge clk);
      bus.start = (n == 5 || n == 12);
    end
    bus.start = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b want=0", bus.busy); end
    checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got=%b want=0", bus.valid); end
    checks++; if (bus.result !== 64'd0) begin errors++; $display("FAIL midrst_result got=%h want=0", bus.result); end
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus.valid) seen = 1;
    end
    checks++; if (seen) begin errors++; $display("FAIL midrst_no_valid got=1 want=0"); end
    last_result = 64'd0;
  endtask

  task automatic test_back_to_back;
    exp_q.push_back(model(1'b1, 32'hFFFF_0000, 32'd12345));
    issue(1'b1, 32'hFFFF_0000, 32'd12345);
    wait_done(40, 1'b0);
    exp_v = exp_q.pop_front();
    checks++; if (!got || lat != 33) begin errors++; $display("FAIL b2b_first_latency got=%0d want=33", lat); end
    checks++; if (bus.result !== exp_v) begin errors++; $display("FAIL b2b_first_result got=%h want=%h", bus.result, exp_v); end
    exp_q.push_back(model(1'b0, 32'hDEAD_BEEF, 32'h0000_0100));
    issue(1'b0, 32'hDEAD_BEEF, 32'h0000_0100);
    wait_done(40, 1'b0);
    exp_v = exp_q.pop_front();
    checks++; if (!got || lat != 33) begin errors++; $display("FAIL b2b_second_latency got=%0d want=33", lat); end
    checks++; if (bus.result !== exp_v) begin errors++; $display("FAIL b2b_second_result got=%h want=%h", bus.result, exp_v); end
    last_result = exp_v;
  endtask

  task automatic test_divzero;
    exp_q.push_back(64'd0);
    issue(1'b1, 32'd1234, 32'd0);
    wait_done(10, 1'b0);
    exp_v = exp_q.pop_front();
    checks++; if (!got || lat != 2) begin errors++; $display("FAIL divzero_latency got=%0d want=2", lat); end
    checks++; if (nbusy != 1) begin errors++; $display("FAIL divzero_busy_cycles got=%0d want=1", nbusy); end
    checks++; if (bus.result !== exp_v) begin errors++; $display("FAIL divzero_result got=%h want=%h", bus.result, exp_v); end
    last_result = exp_v;
  endtask

  initial begin
    bus.start = 1'b0; bus.is_signed = 1'b0; bus.annul = 1'b0;
    bus.a = '0; bus.b = '0;
    rst = 1'b1;
    test_reset();
    test_divu_basic();
    test_vectors();
    test_random();
    test_annul();
    test_annul_with_start();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    test_divzero();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
